// File: rtl/sram_port_arbiter.sv
// Fetch/data arbiter for the single-port 1024x32 OpenRAM macro, 1-cycle reads.
// Define SRAM_RMW_EN to service sub-word stores with a read-modify-write.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [31:0]           i_req_addr,
    output logic                  i_rsp_valid,
    output logic [DATA_WIDTH-1:0] i_rsp_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [31:0]           d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic [3:0]            d_req_wstrb,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    logic [3:0]            starve_cnt;
    logic                  in_rmw;
    logic                  i_sel;
    logic                  grant_ok;
    logic                  i_fire;
    logic                  d_fire;
    logic                  d_nop;
    logic                  d_partial;
    logic                  d_write;
    logic                  d_rd_q;
    logic [ADDR_WIDTH-1:0] i_widx;
    logic [ADDR_WIDTH-1:0] d_widx;
    logic                  unused_addr_bits;

    assign i_widx = i_req_addr[ADDR_WIDTH+1:2];
    assign d_widx = d_req_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{i_req_addr[31:ADDR_WIDTH+2], i_req_addr[1:0],
                                d_req_addr[31:ADDR_WIDTH+2], d_req_addr[1:0]};

`ifdef SRAM_RMW_EN
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] rmw_addr;
    logic [DATA_WIDTH-1:0] rmw_wdata;
    logic [3:0]            rmw_wstrb;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [3:0]            strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign in_rmw    = (state == RMW_WR);
    assign d_partial = d_req_we && (d_req_wstrb != 4'h0) && (d_req_wstrb != 4'hF);
`else
    assign in_rmw    = 1'b0;
    assign d_partial = 1'b0;
`endif

    // Data wins unless the fetch port has waited too long or data is idle.
    assign i_sel       = (starve_cnt >= 4'(STARVE_LIMIT)) || (i_req_valid && !d_req_valid);
    assign grant_ok    = !rst && !in_rmw;
    assign i_req_ready = grant_ok && i_sel;
    assign d_req_ready = grant_ok && !i_sel;
    assign i_fire      = i_req_valid && i_req_ready;
    assign d_fire      = d_req_valid && d_req_ready;
    assign d_nop       = d_req_we && (d_req_wstrb == 4'h0);
    assign d_write     = d_req_we && !d_nop && !d_partial;

    always_comb begin
        csb0  = 1'b1;
        web0  = 1'b1;
        addr0 = '0;
        din0  = '0;
`ifdef SRAM_RMW_EN
        if (in_rmw && !rst) begin
            csb0  = 1'b0;
            web0  = 1'b0;
            addr0 = rmw_addr;
            din0  = merge_bytes(dout0, rmw_wdata, rmw_wstrb);
        end else
`endif
        if (i_fire) begin
            csb0  = 1'b0;
            addr0 = i_widx;
        end else if (d_fire && !d_nop) begin
            csb0  = 1'b0;
            addr0 = d_widx;
            if (d_write) begin
                web0 = 1'b0;
                din0 = d_req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt  <= 4'd0;
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            d_rd_q      <= 1'b0;
        end else begin
            i_rsp_valid <= i_fire;
            d_rsp_valid <= (d_fire && !d_partial) || in_rmw;
            d_rd_q      <= d_fire && !d_req_we;
            if (!i_req_valid || i_fire) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef SRAM_RMW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (d_fire && d_partial) begin
            state <= RMW_WR;
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (d_fire && d_partial) begin
            rmw_addr  <= d_widx;
            rmw_wdata <= d_req_wdata;
            rmw_wstrb <= d_req_wstrb;
        end
    end
`endif

    // Read data is only forwarded while the matching response is valid.
    assign i_rsp_rdata = i_rsp_valid ? dout0 : '0;
    assign d_rsp_rdata = d_rd_q ? dout0 : '0;

endmodule
